oam_scan_arbiter: RTL and testbench

- Parametrised OAM address arbiter with a built-in sprite-scan counter; successor to the fixed 40×4-byte OAM front end.
- Multiplexes four requesters onto a single synchronous OAM port: DMA, scan, render fetch and CPU.
- Generalised in entry count, entry size and data width.
- Adds registered CPU read return, blocked-access reporting and a scan-done pulse.

---
 rtl/oam_scan_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_oam_scan_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_scan_arbiter.sv
// oam_scan_arbiter
// Four-way fixed-priority arbiter for a single synchronous OAM port
// (DMA > SCAN > RENDER > CPU) with a built-in per-line sprite scan counter,
// range checking, CPU read return and blocked-access reporting.
module oam_scan_arbiter #(
    parameter int N_ENTRIES   = 40,
    parameter int ENTRY_BYTES = 4,
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int SCAN_CYCLES = 2,
    parameter int IW          = $clog2(N_ENTRIES)
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          scan_start,
    output logic          scan_busy,
    output logic          scan_done,
    output logic [IW-1:0] scan_idx,

    input  logic          render_active,
    input  logic [AW-1:0] render_a,

    input  logic          dma_run,
    input  logic          dma_wr,
    input  logic [AW-1:0] dma_a,
    input  logic [DW-1:0] dma_d,

    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_d,
    output logic [DW-1:0] cpu_q,
    output logic          cpu_rd_valid,
    output logic          cpu_blocked,

    output logic [AW-1:0] oam_a,
    output logic [DW-1:0] oam_d,
    output logic          oam_cs,
    output logic          oam_we,
    input  logic [DW-1:0] oam_q,
    output logic [1:0]    src
);

    // Phase counter width; a single-cycle scan still keeps one bit.
    localparam int PW  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    // Byte-offset bits inside an entry; the scan always addresses byte 0.
    localparam int EBW = $clog2(ENTRY_BYTES);
    // One extra bit so the limit can equal 2**AW without wrapping.
    localparam logic [AW:0] LIMIT = (AW+1)'(N_ENTRIES * ENTRY_BYTES);

    localparam logic [PW-1:0] PHASE_LAST = PW'(SCAN_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_ENTRIES - 1);

    localparam logic [1:0] SRC_CPU    = 2'd0;
    localparam logic [1:0] SRC_RENDER = 2'd1;
    localparam logic [1:0] SRC_SCAN   = 2'd2;
    localparam logic [1:0] SRC_DMA    = 2'd3;

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    state_t        r_state;
    state_t        w_state_n;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_n;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_n;
    logic          r_done;
    logic          w_done_n;

    logic [AW-1:0] w_scan_a;
    logic [AW-1:0] w_a;
    logic [DW-1:0] w_d;
    logic          w_req_cs;
    logic          w_req_we;
    logic          w_in_range;
    logic          w_cpu_req;
    logic          w_cpu_ok;
    logic          w_cpu_rd_only;

    logic          r_rd_pend;
    logic          r_rd_ok;
    logic [DW-1:0] r_q_hold;
    logic [DW-1:0] w_cpu_q;

    // Scan state, entry index, phase and done pulse; reset aborts any scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_phase <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_idx   <= w_idx_n;
            r_phase <= w_phase_n;
            r_done  <= w_done_n;
        end
    end

    // Scan next-state: phase steps every clock, index steps at phase wrap,
    // last entry's last phase returns to idle with a one-cycle done pulse.
    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_phase_n = r_phase;
        w_done_n  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (scan_start) begin
                    w_state_n = S_SCAN;
                    w_idx_n   = '0;
                    w_phase_n = '0;
                end
            end
            S_SCAN: begin
                if (r_phase == PHASE_LAST) begin
                    w_phase_n = '0;
                    if (r_idx == IDX_LAST) begin
                        w_state_n = S_IDLE;
                        w_idx_n   = '0;
                        w_done_n  = 1'b1;
                    end else begin
                        w_idx_n = r_idx + IW'(1);
                    end
                end else begin
                    w_phase_n = r_phase + PW'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_idx_n   = '0;
                w_phase_n = '0;
            end
        endcase
    end

    // Scan status outputs and the entry base address.
    always_comb begin
        scan_busy = (r_state == S_SCAN);
        scan_done = r_done;
        scan_idx  = r_idx;
        w_scan_a  = AW'(r_idx) << EBW;
    end

    // Fixed-priority owner select and OAM port drive with range gating.
    always_comb begin
        src      = SRC_CPU;
        w_a      = cpu_a;
        w_d      = cpu_d;
        w_req_cs = cpu_rd | cpu_wr;
        w_req_we = cpu_wr;
        if (dma_run) begin
            src      = SRC_DMA;
            w_a      = dma_a;
            w_d      = dma_d;
            w_req_cs = 1'b1;
            w_req_we = dma_wr;
        end else if (scan_busy) begin
            src      = SRC_SCAN;
            w_a      = w_scan_a;
            w_req_cs = 1'b1;
            w_req_we = 1'b0;
        end else if (render_active) begin
            src      = SRC_RENDER;
            w_a      = render_a;
            w_req_cs = 1'b1;
            w_req_we = 1'b0;
        end
        w_in_range = ({1'b0, w_a} < LIMIT);
        oam_a      = w_a;
        oam_d      = w_d;
        oam_cs     = w_req_cs & w_in_range;
        oam_we     = w_req_we & w_in_range;
    end

    // CPU grant and blocked report; when src is CPU, w_in_range checks cpu_a.
    always_comb begin
        w_cpu_req     = cpu_rd | cpu_wr;
        w_cpu_ok      = (src == SRC_CPU) & w_in_range;
        cpu_blocked   = w_cpu_req & ~w_cpu_ok;
        w_cpu_rd_only = cpu_rd & ~cpu_wr;
    end

    // Read-return tracking: pending flag, grant flag and held read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pend <= 1'b0;
            r_rd_ok   <= 1'b0;
            r_q_hold  <= '1;
        end else begin
            r_rd_pend <= w_cpu_rd_only;
            r_rd_ok   <= w_cpu_rd_only & w_cpu_ok;
            if (r_rd_pend) begin
                r_q_hold <= w_cpu_q;
            end
        end
    end

    // oam_q only arrives in the return cycle, so that cycle forwards it
    // (or all-ones for a denied read) and the hold register keeps it after.
    always_comb begin
        if (r_rd_pend) begin
            w_cpu_q = r_rd_ok ? oam_q : '1;
        end else begin
            w_cpu_q = r_q_hold;
        end
        cpu_q        = w_cpu_q;
        cpu_rd_valid = r_rd_pend;
    end

endmodule

// File: tb/tb_oam_scan_arbiter.sv
// Testbench for oam_scan_arbiter: default instance with an OAM RAM model,
// plus a second instance with swept parameters for scan timing.
module tb_oam_scan_arbiter;

    logic       clk;
    logic       reset;

    logic       scan_start;
    logic       scan_busy;
    logic       scan_done;
    logic [5:0] scan_idx;
    logic       render_active;
    logic [7:0] render_a;
    logic       dma_run;
    logic       dma_wr;
    logic [7:0] dma_a;
    logic [7:0] dma_d;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] cpu_a;
    logic [7:0] cpu_d;
    logic [7:0] cpu_q;
    logic       cpu_rd_valid;
    logic       cpu_blocked;
    logic [7:0] oam_a;
    logic [7:0] oam_d;
    logic       oam_cs;
    logic       oam_we;
    logic [7:0] oam_q;
    logic [1:0] src;

    logic       scan_start2;
    logic       scan_busy2;
    logic       scan_done2;
    logic [3:0] scan_idx2;
    logic [7:0] cpu_q2;
    logic       cpu_rd_valid2;
    logic       cpu_blocked2;
    logic [7:0] oam_a2;
    logic [7:0] oam_d2;
    logic       oam_cs2;
    logic       oam_we2;
    logic [7:0] oam_q2;
    logic [1:0] src2;
    logic       zero1;
    logic [7:0] zero8;

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];
    logic [7:0] q_scan  [$];
    logic [7:0] q_rd    [$];

    int n_checks;
    int n_errors;

    oam_scan_arbiter u_dut (
        .clk(clk), .reset(reset),
        .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done), .scan_idx(scan_idx),
        .render_active(render_active), .render_a(render_a),
        .dma_run(dma_run), .dma_wr(dma_wr), .dma_a(dma_a), .dma_d(dma_d),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_q(cpu_q), .cpu_rd_valid(cpu_rd_valid), .cpu_blocked(cpu_blocked),
        .oam_a(oam_a), .oam_d(oam_d), .oam_cs(oam_cs), .oam_we(oam_we), .oam_q(oam_q),
        .src(src)
    );

    oam_scan_arbiter #(
        .N_ENTRIES(10), .ENTRY_BYTES(8), .AW(8), .DW(8), .SCAN_CYCLES(3)
    ) u_dut2 (
        .clk(clk), .reset(reset),
        .scan_start(scan_start2), .scan_busy(scan_busy2), .scan_done(scan_done2), .scan_idx(scan_idx2),
        .render_active(zero1), .render_a(zero8),
        .dma_run(zero1), .dma_wr(zero1), .dma_a(zero8), .dma_d(zero8),
        .cpu_rd(zero1), .cpu_wr(zero1), .cpu_a(zero8), .cpu_d(zero8),
        .cpu_q(cpu_q2), .cpu_rd_valid(cpu_rd_valid2), .cpu_blocked(cpu_blocked2),
        .oam_a(oam_a2), .oam_d(oam_d2), .oam_cs(oam_cs2), .oam_we(oam_we2), .oam_q(oam_q2),
        .src(src2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous OAM RAM model: data appears the cycle after chip select.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            oam_q <= 8'h00;
        end else if (oam_cs) begin
            if (oam_we) mem[oam_a] <= oam_d;
            oam_q <= mem[oam_a];
        end
    end

    task automatic clear_exp_mem;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    endtask

    task automatic test_reset;
        scan_start = 1'b0; render_active = 1'b0; render_a = 8'h00;
        dma_run = 1'b0; dma_wr = 1'b0; dma_a = 8'h00; dma_d = 8'h00;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_a = 8'h00; cpu_d = 8'h00;
        scan_start2 = 1'b0; zero1 = 1'b0; zero8 = 8'h00; oam_q2 = 8'h00;
        reset = 1'b1;
        clear_exp_mem();
        @(negedge clk);
        scan_start = 1'b1;      // must be overridden by reset
        @(negedge clk);
        scan_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (scan_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", scan_busy); end
        n_checks++; if (scan_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", scan_done); end
        n_checks++; if (scan_idx !== 6'd0) begin n_errors++; $display("FAIL reset_idx: got %0d want 0", scan_idx); end
        n_checks++; if (cpu_q !== 8'hFF) begin n_errors++; $display("FAIL reset_cpu_q: got %h want ff", cpu_q); end
        n_checks++; if (cpu_rd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rd_valid: got %b want 0", cpu_rd_valid); end
        n_checks++; if (src !== 2'd0 || oam_cs !== 1'b0 || oam_we !== 1'b0) begin
            n_errors++; $display("FAIL reset_bus: src %0d cs %b we %b want 0 0 0", src, oam_cs, oam_we); end
        n_checks++; if (scan_busy2 !== 1'b0 || cpu_q2 !== 8'hFF) begin
            n_errors++; $display("FAIL reset_dut2: busy %b q %h want 0 ff", scan_busy2, cpu_q2); end
    endtask

    task automatic test_scan_timing;
        logic [7:0] exp_a;
        @(negedge clk);
        scan_start = 1'b1;
        for (int c = 0; c < 80; c++) q_scan.push_back(8'((c / 2) * 4));
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            scan_start = (c == 3);   // ignored while scanning
            #1;
            exp_a = q_scan.pop_front();
            n_checks++; if (scan_busy !== 1'b1 || src !== 2'd2 || oam_cs !== 1'b1 || oam_we !== 1'b0) begin
                n_errors++; $display("FAIL scan_bus c%0d: busy %b src %0d cs %b we %b want 1 2 1 0", c, scan_busy, src, oam_cs, oam_we); end
            n_checks++; if (oam_a !== exp_a) begin
                n_errors++; $display("FAIL scan_addr c%0d: got %h want %h", c, oam_a, exp_a); end
            n_checks++; if (scan_idx !== 6'(c / 2)) begin
                n_errors++; $display("FAIL scan_idx c%0d: got %0d want %0d", c, scan_idx, c / 2); end
            n_checks++; if (scan_done !== 1'b0) begin
                n_errors++; $display("FAIL scan_early_done c%0d: got %b want 0", c, scan_done); end
        end
        @(negedge clk); #1;
        n_checks++; if (scan_busy !== 1'b0 || scan_done !== 1'b1 || scan_idx !== 6'd0) begin
            n_errors++; $display("FAIL scan_end: busy %b done %b idx %0d want 0 1 0", scan_busy, scan_done, scan_idx); end
        @(negedge clk); #1;
        n_checks++; if (scan_done !== 1'b0 || scan_busy !== 1'b0) begin
            n_errors++; $display("FAIL scan_done_pulse: done %b busy %b want 0 0", scan_done, scan_busy); end
    endtask

    task automatic test_cpu_blocked;
        logic [7:0] exp_q;
        @(negedge clk);
        scan_start = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            scan_start = 1'b0;
            cpu_rd = (c == 5);
            cpu_a = 8'h10;
            render_active = (c == 10);
            render_a = 8'h44;
            if (c == 5) q_rd.push_back(8'hFF);
            #1;
            if (c == 5) begin
                n_checks++; if (cpu_blocked !== 1'b1) begin n_errors++; $display("FAIL blk_rd_flag: got %b want 1", cpu_blocked); end
                n_checks++; if (src !== 2'd2 || oam_cs !== 1'b1 || oam_a !== 8'h08 || oam_we !== 1'b0) begin
                    n_errors++; $display("FAIL blk_rd_bus: src %0d cs %b a %h we %b want 2 1 08 0", src, oam_cs, oam_a, oam_we); end
            end
            if (c == 6) begin
                n_checks++; if (cpu_rd_valid !== 1'b1) begin
                    n_errors++; $display("FAIL blk_rd_valid: got %b want 1", cpu_rd_valid);
                end else begin
                    exp_q = q_rd.pop_front();
                    n_checks++; if (cpu_q !== exp_q) begin n_errors++; $display("FAIL blk_rd_q: got %h want %h", cpu_q, exp_q); end
                end
                n_checks++; if (cpu_blocked !== 1'b0) begin n_errors++; $display("FAIL blk_rd_clear: got %b want 0", cpu_blocked); end
            end
            if (c == 10) begin
                n_checks++; if (src !== 2'd2 || oam_a !== 8'h14) begin
                    n_errors++; $display("FAIL scan_over_render: src %0d a %h want 2 14", src, oam_a); end
            end
        end
        @(negedge clk);
        render_active = 1'b1; render_a = 8'h20;
        cpu_wr = 1'b1; cpu_a = 8'h30; cpu_d = 8'h55;
        #1;
        n_checks++; if (src !== 2'd1 || oam_we !== 1'b0 || oam_cs !== 1'b1 || oam_a !== 8'h20) begin
            n_errors++; $display("FAIL render_wr_bus: src %0d we %b cs %b a %h want 1 0 1 20", src, oam_we, oam_cs, oam_a); end
        n_checks++; if (cpu_blocked !== 1'b1) begin n_errors++; $display("FAIL render_wr_blocked: got %b want 1", cpu_blocked); end
        @(negedge clk);
        render_active = 1'b0; cpu_wr = 1'b0;
        cpu_rd = 1'b1; cpu_a = 8'h30;
        q_rd.push_back(exp_mem[8'h30]);
        @(negedge clk);
        cpu_rd = 1'b0;
        #1;
        n_checks++; if (cpu_rd_valid !== 1'b1) begin
            n_errors++; $display("FAIL dropped_wr_valid: got %b want 1", cpu_rd_valid);
        end else begin
            exp_q = q_rd.pop_front();
            n_checks++; if (cpu_q !== exp_q) begin n_errors++; $display("FAIL dropped_wr_q: got %h want %h", cpu_q, exp_q); end
        end
    endtask

    task automatic test_dma_steal;
        logic [7:0] exp_q;
        @(negedge clk);
        scan_start = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            scan_start = 1'b0;
            dma_run = (c >= 20 && c < 30);
            dma_wr = dma_run;
            dma_a = 8'(c - 20);
            dma_d = 8'(8'h60 + c - 20);
            if (dma_run) exp_mem[dma_a] = dma_d;
            #1;
            if (c >= 20 && c < 30) begin
                n_checks++; if (src !== 2'd3 || oam_we !== 1'b1 || oam_cs !== 1'b1 || oam_a !== 8'(c - 20)) begin
                    n_errors++; $display("FAIL dma_bus c%0d: src %0d we %b cs %b a %h want 3 1 1 %h", c, src, oam_we, oam_cs, oam_a, 8'(c - 20)); end
            end else begin
                n_checks++; if (src !== 2'd2) begin n_errors++; $display("FAIL dma_scan_src c%0d: got %0d want 2", c, src); end
            end
            n_checks++; if (scan_idx !== 6'(c / 2)) begin
                n_errors++; $display("FAIL dma_scan_idx c%0d: got %0d want %0d", c, scan_idx, c / 2); end
        end
        dma_run = 1'b0; dma_wr = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (scan_done !== 1'b1 || scan_busy !== 1'b0) begin
            n_errors++; $display("FAIL dma_scan_done: done %b busy %b want 1 0", scan_done, scan_busy); end
        @(negedge clk);
        cpu_rd = 1'b1; cpu_a = 8'h05;
        q_rd.push_back(exp_mem[8'h05]);
        @(negedge clk);
        cpu_rd = 1'b0;
        #1;
        n_checks++; if (cpu_rd_valid !== 1'b1) begin
            n_errors++; $display("FAIL dma_readback_valid: got %b want 1", cpu_rd_valid);
        end else begin
            exp_q = q_rd.pop_front();
            n_checks++; if (cpu_q !== exp_q) begin n_errors++; $display("FAIL dma_readback_q: got %h want %h", cpu_q, exp_q); end
        end
    endtask

    task automatic test_cpu_round_trip;
        logic [7:0] exp_q;
        @(negedge clk);
        cpu_wr = 1'b1; cpu_a = 8'h9F; cpu_d = 8'hA5;
        exp_mem[8'h9F] = 8'hA5;
        #1;
        n_checks++; if (src !== 2'd0 || oam_we !== 1'b1 || oam_cs !== 1'b1 || oam_a !== 8'h9F || oam_d !== 8'hA5) begin
            n_errors++; $display("FAIL rt_write_bus: src %0d we %b cs %b a %h d %h want 0 1 1 9f a5", src, oam_we, oam_cs, oam_a, oam_d); end
        n_checks++; if (cpu_blocked !== 1'b0) begin n_errors++; $display("FAIL rt_write_blocked: got %b want 0", cpu_blocked); end
        @(negedge clk);
        cpu_wr = 1'b0; cpu_rd = 1'b1;
        q_rd.push_back(exp_mem[8'h9F]);
        #1;
        n_checks++; if (oam_cs !== 1'b1 || oam_we !== 1'b0 || cpu_blocked !== 1'b0) begin
            n_errors++; $display("FAIL rt_read_bus: cs %b we %b blk %b want 1 0 0", oam_cs, oam_we, cpu_blocked); end
        @(negedge clk);
        cpu_rd = 1'b0;
        #1;
        n_checks++; if (cpu_rd_valid !== 1'b1) begin
            n_errors++; $display("FAIL rt_read_valid: got %b want 1", cpu_rd_valid);
        end else begin
            exp_q = q_rd.pop_front();
            n_checks++; if (cpu_q !== exp_q) begin n_errors++; $display("FAIL rt_read_q: got %h want %h", cpu_q, exp_q); end
        end
        @(negedge clk); #1;
        n_checks++; if (cpu_rd_valid !== 1'b0 || cpu_q !== 8'hA5) begin
            n_errors++; $display("FAIL rt_hold: valid %b q %h want 0 a5", cpu_rd_valid, cpu_q); end
        @(negedge clk);
        cpu_rd = 1'b1; cpu_a = 8'hA0;
        q_rd.push_back(8'hFF);
        #1;
        n_checks++; if (oam_cs !== 1'b0 || cpu_blocked !== 1'b1) begin
            n_errors++; $display("FAIL oor_read_bus: cs %b blk %b want 0 1", oam_cs, cpu_blocked); end
        @(negedge clk);
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_a = 8'hA0; cpu_d = 8'h77;
        #1;
        n_checks++; if (cpu_rd_valid !== 1'b1) begin
            n_errors++; $display("FAIL oor_read_valid: got %b want 1", cpu_rd_valid);
        end else begin
            exp_q = q_rd.pop_front();
            n_checks++; if (cpu_q !== exp_q) begin n_errors++; $display("FAIL oor_read_q: got %h want %h", cpu_q, exp_q); end
        end
        n_checks++; if (oam_we !== 1'b0 || oam_cs !== 1'b0 || cpu_blocked !== 1'b1) begin
            n_errors++; $display("FAIL oor_write_bus: we %b cs %b blk %b want 0 0 1", oam_we, oam_cs, cpu_blocked); end
        @(negedge clk);
        cpu_wr = 1'b0;
    endtask

    task automatic test_rd_wr_both;
        logic [7:0] exp_q;
        @(negedge clk);
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_a = 8'h40; cpu_d = 8'h3C;
        exp_mem[8'h40] = 8'h3C;
        #1;
        n_checks++; if (oam_we !== 1'b1 || oam_d !== 8'h3C) begin
            n_errors++; $display("FAIL both_write: we %b d %h want 1 3c", oam_we, oam_d); end
        @(negedge clk);
        cpu_wr = 1'b0;   // cpu_rd stays high: a plain read this cycle
        q_rd.push_back(exp_mem[8'h40]);
        #1;
        n_checks++; if (cpu_rd_valid !== 1'b0) begin
            n_errors++; $display("FAIL both_no_return: valid %b want 0", cpu_rd_valid); end
        @(negedge clk);
        cpu_rd = 1'b0;
        #1;
        n_checks++; if (cpu_rd_valid !== 1'b1) begin
            n_errors++; $display("FAIL both_readback_valid: got %b want 1", cpu_rd_valid);
        end else begin
            exp_q = q_rd.pop_front();
            n_checks++; if (cpu_q !== exp_q) begin n_errors++; $display("FAIL both_readback_q: got %h want %h", cpu_q, exp_q); end
        end
    endtask

    task automatic test_reset_mid_scan;
        @(negedge clk);
        scan_start = 1'b1;
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            scan_start = (c == 33);
            reset = (c == 33);
        end
        clear_exp_mem();
        @(negedge clk);
        scan_start = 1'b0; reset = 1'b0;
        #1;
        n_checks++; if (scan_busy !== 1'b0 || scan_idx !== 6'd0 || scan_done !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset: busy %b idx %0d done %b want 0 0 0", scan_busy, scan_idx, scan_done); end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); #1;
            n_checks++; if (scan_done !== 1'b0 || scan_busy !== 1'b0) begin
                n_errors++; $display("FAIL mid_reset_quiet c%0d: done %b busy %b want 0 0", c, scan_done, scan_busy); end
        end
    endtask

    task automatic test_rd_reset;
        @(negedge clk);
        cpu_rd = 1'b1; cpu_a = 8'h12; reset = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0; reset = 1'b0;
        #1;
        n_checks++; if (cpu_rd_valid !== 1'b0 || cpu_q !== 8'hFF) begin
            n_errors++; $display("FAIL rd_reset: valid %b q %h want 0 ff", cpu_rd_valid, cpu_q); end
    endtask

    task automatic test_param_sweep;
        logic [7:0] exp_a;
        @(negedge clk);
        scan_start2 = 1'b1;
        for (int c = 0; c < 30; c++) q_scan.push_back(8'((c / 3) * 8));
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            scan_start2 = 1'b0;
            #1;
            exp_a = q_scan.pop_front();
            n_checks++; if (oam_a2 !== exp_a || oam_cs2 !== 1'b1 || src2 !== 2'd2) begin
                n_errors++; $display("FAIL sweep_addr c%0d: a %h cs %b src %0d want %h 1 2", c, oam_a2, oam_cs2, src2, exp_a); end
            n_checks++; if (scan_idx2 !== 4'(c / 3) || scan_done2 !== 1'b0 || scan_busy2 !== 1'b1) begin
                n_errors++; $display("FAIL sweep_idx c%0d: idx %0d done %b busy %b want %0d 0 1", c, scan_idx2, scan_done2, scan_busy2, c / 3); end
        end
        @(negedge clk); #1;
        n_checks++; if (scan_done2 !== 1'b1 || scan_busy2 !== 1'b0 || scan_idx2 !== 4'd0) begin
            n_errors++; $display("FAIL sweep_done: done %b busy %b idx %0d want 1 0 0", scan_done2, scan_busy2, scan_idx2); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_scan_timing();
        test_cpu_blocked();
        test_dma_steal();
        test_cpu_round_trip();
        test_rd_wr_both();
        test_reset_mid_scan();
        test_rd_reset();
        test_param_sweep();
        n_checks++; if (q_rd.size() != 0 || q_scan.size() != 0) begin
            n_errors++; $display("FAIL scoreboard_leftover: rd %0d scan %0d want 0 0", q_rd.size(), q_scan.size()); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
